ps2_key_sched: RTL
==================

# ps2_key_sched

Key-event scheduler between the PS/2 keyboard driver and the game FSM. It samples the driver's 16-bit two-byte keyword across the clock boundary and waits for each new keyword to settle. It then decodes make/break sequences into a per-key held bitmap and queues one press event per physical key-down in a small FIFO. The game FSM drains the FIFO with a valid/ready handshake, so flaps and menu keys are never lost or double-counted, whatever the keyboard typematic rate or game frame timing.

## Interface
- STABLE_CYC, 4: sys_clk cycles a synchronized keyword must hold unchanged before decode (≥1)
- FIFO_DEPTH, 4: event FIFO entries (power of two, ≥2)
- sys_clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset; clears every register
- key_code  in  16  keyword from ps2_kbd_driver, asynchronous to sys_clk; [7:0] newest byte, [15:8] previous byte
- ev_valid  out  1  FIFO non-empty; ev_key is meaningful
- ev_key  out  3  head-of-FIFO key id
- ev_ready  in  1  consumer accepts head when ev_valid=1
- held  out  8  current pressed state per key id, bit n = id n
- overflow  out  1  sticky: a press event was dropped on full FIFO
- clr_overflow  in  1  synchronous clear of overflow

## Operation
- Key ids: 0=0x1C (left), 1=0x23 (right), 2=0x1D (up), 3=0x1B (down), 4=0x16 (choose1), 5=0x1E (choose2), 6=0x75 (up2), 7=0x5A (enter). All other codes are ignored.
- Synchronizer: two-stage register chain key_code→s1→s2. The FSM sees only s2.
- State registers: last_kw (16 bits), cand (16 bits), cnt (enough bits for STABLE_CYC).
- FSM states are IDLE, SETTLE and DECODE. Reset state is IDLE, with last_kw=cand=0 and cnt=0.
- IDLE: if s2≠last_kw, set cand←s2, cnt←1 and go to SETTLE. Otherwise stay in IDLE.
- SETTLE, when s2≠cand: set cand←s2, cnt←1 (restart) and stay in SETTLE.
- SETTLE, when s2=cand and cnt=STABLE_CYC: go to DECODE.
- SETTLE, otherwise: cnt←cnt+1.
- DECODE lasts exactly one cycle, sets last_kw←cand, applies the decode rule below, then returns to IDLE.
- Decode rules on cand:
  - low byte 0xF0 or 0xE0: prefix only; no action.
  - high byte 0xF0 and low byte maps to an id: release. Clear held[id]. No event is emitted, even if the key was not held.
  - otherwise, low byte maps to an id: make, with high byte 0xE0 allowed. If held[id]=0, set held[id] and push id into the FIFO. If held[id]=1 (typematic repeat), no action.
- A keyword equal to last_kw never reaches DECODE, so identical repeated keywords (e.g. 0x1D1D) produce nothing.
- FIFO behaviour:
  - Show-ahead: ev_key always shows the head entry, and ev_valid = not empty.
  - Pop happens when ev_valid & ev_ready. Raising ev_ready while empty has no effect.
  - On a push while full with no pop in the same cycle, the event is dropped and overflow←1. held is still updated.
  - Push and pop in the same cycle are both performed, including when full (no drop) and when empty is not the case. Occupancy is unchanged.
  - Pointer widths are log2(FIFO_DEPTH)+1. Pointers wrap modulo 2·FIFO_DEPTH.
- overflow: if clr_overflow and a drop occur in the same cycle, the set wins.
- Reset mid-operation: the FSM returns to IDLE, the FIFO is emptied, and held, overflow and last_kw are all 0. A non-zero key_code present at reset release is treated as new. For example, 0x001D yields an up press after the normal latency.

## Timing
- Reset values: ev_valid=0, ev_key=0, held=0x00, overflow=0.
- Latency, with key_code changing and then holding: s2 updates at edge 2 and SETTLE is entered at edge 3.
  - DECODE is entered at edge 3+STABLE_CYC.
  - The FIFO write and held update happen at edge 4+STABLE_CYC. ev_valid is high after that edge, which is 8 edges at default.
- held for a release changes at the same edge (4+STABLE_CYC).
- Glitch rejection: any change of s2 during SETTLE restarts the full STABLE_CYC window from the new value.
- A pop takes effect at the accepting edge. The next entry, or ev_valid=0, is visible after that edge.
- Back-to-back keywords are processed serially. The minimum spacing per decoded keyword is STABLE_CYC+2 cycles, far shorter than one PS/2 byte time.

## Test plan
- Reset, then key_code=0x001D held with ev_ready=0 → ev_valid=1 and ev_key=2 after edge 8, held=0x04. Subsequent 0x1D1D produces no second event.
- Sequence 0x001D, 0x1DF0, 0xF01D, 0x1D1D, each held 20 cycles, ev_ready=1 → exactly two events with id 2. held goes 0x04→0x04→0x00→0x04.
- key_code toggling 0x0023/0x0000 every 2 cycles for 30 cycles, then held at 0x0023 → a single event id 1, only after 4 stable cycles. No event is produced for 0x0000.
- Five distinct presses (0x1C, 0x23, 0x1B, 0x16, 0x5A, each with releases) with ev_ready=0:
  - FIFO ends holding ids 0,1,3,4 and overflow=1.
  - With ev_ready=1, ev_key reads 0,1,3,4 on successive cycles, then ev_valid=0.
  - clr_overflow pulse → overflow=0.
- FIFO full with a push arriving while ev_ready=1 → no drop, overflow stays 0, occupancy stays 4.
- Extended keyword 0xE075 → event id 6. 0xF075 → held[6]=0. rst_n asserted mid-SETTLE → all outputs 0 immediately, no event from the aborted keyword.

Source files
------------

// File: rtl/ps2_key_sched.sv
// PS/2 key-event scheduler: synchronizes the driver keyword, waits for it to settle,
// decodes make/break into a held bitmap and queues one press event per key-down.
module ps2_key_sched #(
  parameter int unsigned STABLE_CYC = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [15:0] key_code,
  output logic        ev_valid,
  output logic [2:0]  ev_key,
  input  logic        ev_ready,
  output logic [7:0]  held,
  output logic        overflow,
  input  logic        clr_overflow
);

  localparam int unsigned CntW  = $clog2(STABLE_CYC + 1);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYC);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [AddrW:0]  PtrOne = (AddrW + 1)'(1);

  typedef enum logic [1:0] {StIdle, StSettle, StDecode} state_e;

  state_e          r_state, w_state_d;
  logic [15:0]     r_s1, r_s2;
  logic [15:0]     r_last_kw, w_last_kw_d;
  logic [15:0]     r_cand, w_cand_d;
  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic [7:0]      r_held, w_held_d;
  logic            r_overflow;

  logic [2:0]      r_mem [FIFO_DEPTH];
  logic [AddrW:0]  r_wr_ptr, r_rd_ptr;

  logic            w_hit;
  logic [2:0]      w_id;
  logic            w_release, w_push, w_pop, w_wr_en, w_drop;
  logic            w_empty, w_full;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= key_code;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_last_kw <= '0;
      r_cand    <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_last_kw <= w_last_kw_d;
      r_cand    <= w_cand_d;
      r_cnt     <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_last_kw_d = r_last_kw;
    w_cand_d    = r_cand;
    w_cnt_d     = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (r_s2 != r_last_kw) begin
          w_cand_d  = r_s2;
          w_cnt_d   = CntOne;
          w_state_d = StSettle;
        end
      end
      StSettle: begin
        // Any change restarts the full stability window from the new value.
        if (r_s2 != r_cand) begin
          w_cand_d = r_s2;
          w_cnt_d  = CntOne;
        end else if (r_cnt == CntMax) begin
          w_state_d = StDecode;
        end else begin
          w_cnt_d = r_cnt + CntOne;
        end
      end
      StDecode: begin
        w_last_kw_d = r_cand;
        w_state_d   = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Prefix bytes 0xF0/0xE0 are absent from this table, so a bare prefix never acts.
  always_comb begin
    w_hit = 1'b1;
    w_id  = 3'd0;
    case (r_cand[7:0])
      8'h1C:   w_id = 3'd0;
      8'h23:   w_id = 3'd1;
      8'h1D:   w_id = 3'd2;
      8'h1B:   w_id = 3'd3;
      8'h16:   w_id = 3'd4;
      8'h1E:   w_id = 3'd5;
      8'h75:   w_id = 3'd6;
      8'h5A:   w_id = 3'd7;
      default: w_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_release = 1'b0;
    w_push    = 1'b0;
    w_held_d  = r_held;
    if (r_state == StDecode && w_hit) begin
      if (r_cand[15:8] == 8'hF0) begin
        w_release        = 1'b1;
        w_held_d[w_id]   = 1'b0;
      end else if (!r_held[w_id]) begin
        w_push           = 1'b1;
        w_held_d[w_id]   = 1'b1;
      end
    end
  end

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]) &&
                   (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]);
  assign w_pop   = !w_empty && ev_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr[AddrW-1:0]] <= w_id;
        r_wr_ptr                   <= r_wr_ptr + PtrOne;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PtrOne;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_held <= w_held_d;
      if (w_drop) r_overflow <= 1'b1;
      else if (clr_overflow) r_overflow <= 1'b0;
    end
  end

  assign ev_valid = !w_empty;
  assign ev_key   = r_mem[r_rd_ptr[AddrW-1:0]];
  assign held     = r_held;
  assign overflow = r_overflow;

endmodule
